// File: rtl/loader_mem_arbiter.sv
// Arbitrates the single SDRAM byte port between the ROM loader write FIFO, the PPU and the CPU.
// Optional CPU starvation guard is built when ARB_STARVE_GUARD_EN is defined.
module loader_mem_arbiter #(
  parameter int unsigned ADDR_W       = 22,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_overflow,
  output logic              ld_pending,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_ack,
  output logic [7:0]        ppu_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      STARVE_LIMIT == 0) begin : g_bad_param
    $error("loader_mem_arbiter: illegal parameter set");
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } ld_ent_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_PPU, OWN_CPU} own_t;

  ld_ent_t          fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full, fifo_empty, push, pop;
  state_t           state, state_nx;
  own_t             owner, grant;
  logic             cpu_force;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // Full is judged before this cycle's pop, so a push into a full FIFO is dropped.
  assign push       = ld_we && !fifo_full;
  assign pop        = (grant == OWN_LD);
  assign ld_pending = !fifo_empty || (state != IDLE && owner == OWN_LD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ld_overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{addr: ld_addr, data: ld_data};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ld_we && fifo_full) ld_overflow <= 1'b1;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              starve_cnt <= '0;
    else if (!cpu_req || grant == OWN_CPU)     starve_cnt <= '0;
    else if (starve_cnt != SC_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  end

  assign cpu_force = cpu_req && (starve_cnt == SC_W'(STARVE_LIMIT));
`else
  assign cpu_force = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = OWN_NONE;
    case (state)
      IDLE: begin
        if (!fifo_empty)  grant = OWN_LD;
        else if (cpu_force) grant = OWN_CPU;
        else if (ppu_req) grant = OWN_PPU;
        else if (cpu_req) grant = OWN_CPU;
        if (grant != OWN_NONE) state_nx = ISSUE;
      end
      ISSUE:   state_nx = WAIT;
      WAIT:    if (mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= OWN_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ppu_ack   <= 1'b0;
      ppu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      ppu_ack <= 1'b0;
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != OWN_NONE) owner <= grant;
          case (grant)
            OWN_LD: begin
              mem_we    <= 1'b1;
              mem_addr  <= fifo[rd_ptr].addr;
              mem_wdata <= fifo[rd_ptr].data;
            end
            OWN_PPU: begin
              mem_we    <= 1'b0;
              mem_addr  <= ppu_addr;
              mem_wdata <= '0;
            end
            OWN_CPU: begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
            default: ;
          endcase
        end
        ISSUE: mem_req <= 1'b1;
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (owner == OWN_PPU) begin
              ppu_ack   <= 1'b1;
              ppu_rdata <= mem_rdata;
            end
            if (owner == OWN_CPU) begin
              cpu_ack <= 1'b1;
              if (!mem_we) cpu_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_loader_mem_arbiter.sv
// Scoreboard bench for loader_mem_arbiter: expected memory/ack traffic is queued, monitors compare.
module tb_loader_mem_arbiter;
  localparam int AW = 22;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic          ld_overflow, ld_pending;
  logic          ppu_req = 1'b0;
  logic [AW-1:0] ppu_addr = '0;
  logic          ppu_ack;
  logic [7:0]    ppu_rdata;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = '0;
  logic          mem_ack = 1'b0;

  loader_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_overflow(ld_overflow), .ld_pending(ld_pending),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } mreq_t;

  mreq_t       exp_mem[$];
  logic [7:0]  exp_ppu[$];
  logic [7:0]  exp_cpu[$];
  int          pass_cnt = 0, tot_cnt = 0;
  int unsigned cyc = 0, ack_cyc = 0;
  bit          hold_ack = 1'b0;
  int          ack_delay = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic bad(input string name);
    tot_cnt++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Memory model: ack after ack_delay cycles of mem_req, read data = addr[7:0]^A5.
  initial begin
    int mcnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!mem_req) mcnt = 0;
      else begin
        mcnt++;
        if (mcnt >= ack_delay && !hold_ack) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr[7:0] ^ 8'hA5;
        end
      end
    end
  end

  // Memory-side monitor.
  logic  prev_req = 1'b0;
  mreq_t cur_req = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_req && !prev_req) begin
        if (exp_mem.size() == 0) bad("mem_unexpected_req");
        else begin
          mreq_t e;
          e = exp_mem.pop_front();
          cur_req = '{we: mem_we, addr: mem_addr, data: mem_wdata};
          chk("mem_req_fields", 32'(cur_req), 32'(e));
        end
      end
      if (mem_req && mem_ack) begin
        chk("mem_hold_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(cur_req));
        ack_cyc = cyc;
      end
    end
    prev_req = mem_req;
  end

  // Requester-side ack monitor.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ppu_ack) begin
        if (exp_ppu.size() == 0) bad("ppu_unexpected_ack");
        else begin
          chk("ppu_rdata", 32'(ppu_rdata), 32'(exp_ppu.pop_front()));
          chk("ppu_ack_latency", cyc, ack_cyc + 1);
        end
      end
      if (cpu_ack) begin
        if (exp_cpu.size() == 0) bad("cpu_unexpected_ack");
        else begin
          chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu.pop_front()));
          chk("cpu_ack_latency", cyc, ack_cyc + 1);
        end
      end
    end
  end

  task automatic ld_burst(input logic [AW-1:0] a0, input logic [7:0] d0, input int n, input int nexp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ld_we   = 1'b1;
      ld_addr = a0 + AW'(i);
      ld_data = d0 + 8'(i);
      if (i < nexp) exp_mem.push_back('{we: 1'b1, addr: a0 + AW'(i), data: d0 + 8'(i)});
    end
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!ld_pending && !mem_req && exp_mem.size() == 0 && exp_ppu.size() == 0 &&
          exp_cpu.size() == 0) break;
    end
    if (i == budget) bad({name, "_timeout"});
    repeat (3) @(negedge clk);
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    int i;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cpu_ack) break;
    end
    if (i == 200) bad("cpu_ack_timeout");
    cpu_req = 1'b0;
  endtask

  task automatic ppu_access(input logic [AW-1:0] a, input int n_acks);
    int i, got;
    got = 0;
    @(posedge clk); #1;
    ppu_req = 1'b1; ppu_addr = a;
    for (i = 0; i < 400 && got < n_acks; i++) begin
      @(posedge clk); #1;
      if (ppu_ack) got++;
    end
    if (got < n_acks) bad("ppu_ack_timeout");
    ppu_req = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_acks", 32'({ppu_ack, cpu_ack}), 0);
    chk("rst_ld_flags", 32'({ld_overflow, ld_pending}), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Loader burst, 4 in-order writes
    ack_delay = 3;
    ld_burst(22'h000000, 8'hA0, 4, 4);
    chk("burst_pending", 32'(ld_pending), 1);
    wait_idle("burst", 200);
    chk("burst_pending_done", 32'(ld_pending), 0);
    chk("burst_overflow", 32'(ld_overflow), 0);

    // Overflow: first in flight, four buffered, sixth dropped
    hold_ack = 1'b1;
    ld_burst(22'h000010, 8'hB0, 6, 5);
    @(negedge clk);
    chk("ovf_set", 32'(ld_overflow), 1);
    chk("ovf_pending", 32'(ld_pending), 1);
    hold_ack = 1'b0;
    wait_idle("ovf_drain", 300);
    chk("ovf_sticky", 32'(ld_overflow), 1);
    chk("ovf_pending_done", 32'(ld_pending), 0);

    // PPU beats CPU when both rise together
    exp_mem.push_back('{we: 1'b0, addr: 22'h0000FF, data: 8'h00});
    exp_mem.push_back('{we: 1'b0, addr: 22'h000100, data: 8'h00});
    exp_ppu.push_back(8'h5A);
    exp_cpu.push_back(8'hA5);
    fork
      ppu_access(22'h0000FF, 1);
      cpu_access(1'b0, 22'h000100, 8'h00);
    join
    wait_idle("ppu_cpu", 200);

    // CPU write; read data register is untouched
    exp_mem.push_back('{we: 1'b1, addr: 22'h3C0010, data: 8'h77});
    exp_cpu.push_back(8'hA5);
    cpu_access(1'b1, 22'h3C0010, 8'h77);
    wait_idle("cpu_wr", 200);

`ifdef ARB_STARVE_GUARD_EN
    // Continuous PPU traffic: CPU forced in after its wait counter saturates
    ack_delay = 1;
    for (int i = 0; i < 11; i++) exp_mem.push_back('{we: 1'b0, addr: 22'h0000FF, data: 8'h00});
    exp_mem.push_back('{we: 1'b0, addr: 22'h000120, data: 8'h00});
    exp_mem.push_back('{we: 1'b0, addr: 22'h0000FF, data: 8'h00});
    for (int i = 0; i < 12; i++) exp_ppu.push_back(8'h5A);
    exp_cpu.push_back(8'h85);
    fork
      ppu_access(22'h0000FF, 12);
      cpu_access(1'b0, 22'h000120, 8'h00);
    join
    wait_idle("starve", 400);
    ack_delay = 3;
`endif

    // Reset while WAIT: access abandoned, FIFO flushed, no acks
    hold_ack = 1'b1;
    exp_mem.push_back('{we: 1'b0, addr: 22'h000200, data: 8'h00});
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h000200; cpu_wdata = 8'h00;
    begin
      int i;
      for (i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (mem_req) break;
      end
      if (i == 20) bad("rst_wait_mem_req_timeout");
    end
    ld_burst(22'h000300, 8'hC0, 2, 0);
    @(negedge clk); #2;
    chk("pre_rst_pending", 32'(ld_pending), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_mem_req", 32'(mem_req), 0);
    chk("rst_fifo_empty", 32'(ld_pending), 0);
    chk("rst_overflow_clr", 32'(ld_overflow), 0);
    cpu_req  = 1'b0;
    hold_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_mem_req", 32'(mem_req), 0);
    chk("queues_drained", exp_mem.size() + exp_ppu.size() + exp_cpu.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
